pipelined_decode_stage: RTL and testbench

//  Registered ID-stage control unit for the pipelined core. Decodes {op,fn} into the

---
 rtl/pipelined_decode_stage_if.sv | 31 +++
 rtl/pipelined_decode_stage.sv | 214 +++++++++++++++++++++
 tb/tb_pipelined_decode_stage.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_decode_stage_if.sv
// Handshake and field bundle between the IF/ID register, the decode stage and execute.
// The slave modport is the decode stage; master is whoever drives it.
interface pipelined_decode_stage_if #(
    parameter int RA_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [5:0]      op;
    logic [5:0]      fn;
    logic [RA_W-1:0] rs;
    logic [RA_W-1:0] rt;
    logic [RA_W-1:0] rd;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [20:0]     ctrl;
    logic [RA_W-1:0] out_rs;
    logic [RA_W-1:0] out_rt;
    logic [RA_W-1:0] out_dest;
    logic            illegal;

    modport master (
        output in_valid, op, fn, rs, rt, rd, flush, out_ready,
        input  in_ready, out_valid, ctrl, out_rs, out_rt, out_dest, illegal
    );

    modport slave (
        input  in_valid, op, fn, rs, rt, rd, flush, out_ready,
        output in_ready, out_valid, ctrl, out_rs, out_rt, out_dest, illegal
    );
endinterface

// File: rtl/pipelined_decode_stage.sv
// Registered ID stage: decodes {op,fn} into the control bundle held in the ID/EX register.
// Stalls upstream on load-use hazards and while a multi-cycle MUL occupies the stage.
module pipelined_decode_stage #(
    parameter int MUL_CYCLES = 3,
    parameter bit ENABLE_MUL = 1'b1,
    parameter int RA_W       = 5
) (
    input logic                     clock,
    input logic                     reset,
    pipelined_decode_stage_if.slave bus
);
    typedef struct packed {
        logic       selimregb;
        logic [1:0] selbrjumpz;
        logic       selregdest;
        logic       selwsource;
        logic       writereg;
        logic       writeov;
        logic       unsig;
        logic [1:0] shiftop;
        logic [2:0] aluop;
        logic       selalushift;
        logic [2:0] compop;
        logic [1:0] selpctype;
        logic       readmem;
        logic       writemem;
    } ctrl_t;

    localparam logic [1:0] BJ_BRANCH = 2'b00, BJ_JUMP = 2'b01, BJ_SEQ = 2'b10;
    localparam logic [1:0] PC_BRANCH = 2'b01, PC_JUMP = 2'b10, PC_REG = 2'b11;
    localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010,
                           ALU_NOR = 3'b100, ALU_XOR = 3'b101, ALU_SUB = 3'b110,
                           ALU_MUL = 3'b111;
    localparam logic [1:0] SH_SRLV = 2'b00, SH_SRAV = 2'b01, SH_SLLV = 2'b10;
    localparam logic [2:0] CMP_BEQ = 3'b000, CMP_BLEZ = 3'b010, CMP_BGTZ = 3'b011,
                           CMP_BNE = 3'b101;

    ctrl_t dec;
    logic  dec_illegal;
    logic  dec_is_mul;
    logic  reads_rs;
    logic  reads_rt;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        dec         = '0;
        dec_illegal = 1'b0;
        dec_is_mul  = 1'b0;
        reads_rs    = 1'b0;
        reads_rt    = 1'b0;
        case (bus.op)
            6'h00: begin
                dec.selbrjumpz = BJ_SEQ;
                dec.selregdest = 1'b1;
                dec.writereg   = 1'b1;
                reads_rs       = 1'b1;
                reads_rt       = 1'b1;
                case (bus.fn)
                    6'h04: begin dec.selalushift = 1'b1; dec.shiftop = SH_SLLV; end
                    6'h06: begin dec.selalushift = 1'b1; dec.shiftop = SH_SRLV; end
                    6'h07: begin dec.selalushift = 1'b1; dec.shiftop = SH_SRAV; end
                    6'h08: begin
                        dec.selbrjumpz = BJ_JUMP;
                        dec.selpctype  = PC_REG;
                        dec.selregdest = 1'b0;
                        dec.writereg   = 1'b0;
                    end
                    6'h20: begin dec.aluop = ALU_ADD; dec.writeov = 1'b1; end
                    6'h21: begin dec.aluop = ALU_ADD; dec.unsig = 1'b1; end
                    6'h22: begin dec.aluop = ALU_SUB; dec.writeov = 1'b1; end
                    6'h23: begin dec.aluop = ALU_SUB; dec.unsig = 1'b1; end
                    6'h24: dec.aluop = ALU_AND;
                    6'h25: dec.aluop = ALU_OR;
                    6'h26: dec.aluop = ALU_XOR;
                    6'h27: dec.aluop = ALU_NOR;
                    6'h28: begin
                        dec.aluop   = ALU_MUL;
                        dec_is_mul  = 1'b1;
                        dec_illegal = !ENABLE_MUL;
                    end
                    default: dec_illegal = 1'b1;
                endcase
            end
            6'h02: begin dec.selbrjumpz = BJ_JUMP; dec.selpctype = PC_JUMP; end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                dec.selbrjumpz = BJ_BRANCH;
                dec.selpctype  = PC_BRANCH;
                reads_rs       = 1'b1;
                reads_rt       = (bus.op == 6'h04) || (bus.op == 6'h05);
                case (bus.op[1:0])
                    2'b00:   dec.compop = CMP_BEQ;
                    2'b01:   dec.compop = CMP_BNE;
                    2'b10:   dec.compop = CMP_BLEZ;
                    default: dec.compop = CMP_BGTZ;
                endcase
            end
            6'h08, 6'h09, 6'h0A: begin
                dec.selbrjumpz = BJ_SEQ;
                dec.selimregb  = 1'b1;
                dec.writereg   = 1'b1;
                dec.aluop      = ALU_ADD;
                dec.writeov    = (bus.op == 6'h08);
                dec.unsig      = (bus.op != 6'h08);
                reads_rs       = 1'b1;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                dec.selbrjumpz = BJ_SEQ;
                dec.selimregb  = 1'b1;
                dec.writereg   = 1'b1;
                dec.unsig      = 1'b1;
                dec.aluop      = (bus.op == 6'h0C) ? ALU_AND :
                                 (bus.op == 6'h0D) ? ALU_OR : ALU_XOR;
                reads_rs       = 1'b1;
            end
            6'h23: begin
                dec.selbrjumpz = BJ_SEQ;
                dec.selimregb  = 1'b1;
                dec.selwsource = 1'b1;
                dec.writereg   = 1'b1;
                dec.aluop      = ALU_ADD;
                dec.readmem    = 1'b1;
                reads_rs       = 1'b1;
            end
            6'h2B: begin
                dec.selbrjumpz = BJ_SEQ;
                dec.selimregb  = 1'b1;
                dec.aluop      = ALU_ADD;
                dec.writemem   = 1'b1;
                reads_rs       = 1'b1;
                reads_rt       = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec        = '0;
            dec_is_mul = 1'b0;
            reads_rs   = 1'b0;
            reads_rt   = 1'b0;
        end
    end

    ctrl_t           ctrl_q;
    logic [RA_W-1:0] rs_q;
    logic [RA_W-1:0] rt_q;
    logic [RA_W-1:0] dest_q;
    logic            valid_q;
    logic            illegal_q;
    logic            mul_busy;
    logic [3:0]      mul_count;
    logic            hazard;
    logic            accept;

    // A held LW blocks any incoming instruction that reads its destination register.
    assign hazard = valid_q && ctrl_q.readmem && (dest_q != '0) &&
                    ((reads_rs && (dest_q == bus.rs)) || (reads_rt && (dest_q == bus.rt)));

    assign bus.in_ready = !reset && !bus.flush && !hazard && !mul_busy &&
                          (!valid_q || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ctrl_q    <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            dest_q    <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            mul_busy  <= 1'b0;
            mul_count <= '0;
        end else if (bus.flush) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            mul_busy  <= 1'b0;
            mul_count <= '0;
        end else begin
            // The busy flag outlives the count by one cycle so nothing enters beside a fresh MUL result.
            if (mul_busy) begin
                if (mul_count == 4'd1) begin
                    mul_count <= '0;
                    valid_q   <= 1'b1;
                end else if (mul_count == 4'd0) begin
                    mul_busy <= 1'b0;
                end else begin
                    mul_count <= mul_count - 4'd1;
                end
            end
            if (valid_q && bus.out_ready) begin
                valid_q <= 1'b0;
            end
            if (accept) begin
                ctrl_q    <= dec;
                rs_q      <= bus.rs;
                rt_q      <= bus.rt;
                dest_q    <= dec.selregdest ? bus.rd : bus.rt;
                illegal_q <= dec_illegal;
                if (dec_is_mul && (MUL_CYCLES > 1)) begin
                    valid_q   <= 1'b0;
                    mul_busy  <= 1'b1;
                    mul_count <= 4'(MUL_CYCLES - 1);
                end else begin
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.ctrl      = ctrl_q;
    assign bus.out_rs    = rs_q;
    assign bus.out_rt    = rt_q;
    assign bus.out_dest  = dest_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Scoreboard bench: stimulus pushes hand-computed decodes, a monitor pops them on each consume.
// A second instance built without MUL support checks that MUL decodes as illegal there.
module tb_pipelined_decode_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   consumed = 0;

    always #5 clk = ~clk;

    pipelined_decode_stage_if #(.RA_W(5)) bus ();
    pipelined_decode_stage_if #(.RA_W(5)) bus2 ();

    pipelined_decode_stage #(.MUL_CYCLES(3), .ENABLE_MUL(1'b1), .RA_W(5)) dut (
        .clock(clk), .reset(rst), .bus(bus)
    );
    pipelined_decode_stage #(.MUL_CYCLES(1), .ENABLE_MUL(1'b0), .RA_W(5)) dut_nomul (
        .clock(clk), .reset(rst), .bus(bus2)
    );

    typedef struct {
        logic [20:0] ctrl;
        logic [4:0]  dest;
        logic        ill;
        logic [4:0]  rs;
    } exp_t;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [20:0] ctrl;
        logic        ill;
        logic [4:0]  dest;
    } vec_t;

    exp_t exp_q[$];

    // Bundle layout (bit 20 down): selimregb, selbrjumpz[1:0], selregdest, selwsource, writereg,
    // writeov, unsig, shiftop[1:0], aluop[2:0] at [10:8], selalushift, compop, selpctype, readmem, writemem.
    localparam logic [20:0] C_ADD = 21'h0AC200, C_MUL = 21'h0A8700, C_LW = 21'h198202;

    vec_t vecs[16] = '{
        '{6'h00, 6'h22, 5'd1,  5'd2,  5'd4,  21'h0AC600, 1'b0, 5'd4},
        '{6'h00, 6'h25, 5'd2,  5'd3,  5'd5,  21'h0A8100, 1'b0, 5'd5},
        '{6'h00, 6'h26, 5'd3,  5'd4,  5'd6,  21'h0A8500, 1'b0, 5'd6},
        '{6'h00, 6'h27, 5'd4,  5'd5,  5'd7,  21'h0A8400, 1'b0, 5'd7},
        '{6'h00, 6'h21, 5'd5,  5'd6,  5'd8,  21'h0AA200, 1'b0, 5'd8},
        '{6'h23, 6'h00, 5'd1,  5'd10, 5'd0,  21'h198202, 1'b0, 5'd10},
        '{6'h2B, 6'h00, 5'd11, 5'd12, 5'd0,  21'h180201, 1'b0, 5'd12},
        '{6'h00, 6'h04, 5'd1,  5'd2,  5'd13, 21'h0A9080, 1'b0, 5'd13},
        '{6'h04, 6'h00, 5'd1,  5'd2,  5'd0,  21'h000004, 1'b0, 5'd2},
        '{6'h05, 6'h00, 5'd3,  5'd4,  5'd0,  21'h000054, 1'b0, 5'd4},
        '{6'h02, 6'h00, 5'd0,  5'd0,  5'd0,  21'h040008, 1'b0, 5'd0},
        '{6'h00, 6'h08, 5'd31, 5'd0,  5'd0,  21'h04000C, 1'b0, 5'd0},
        '{6'h08, 6'h00, 5'd1,  5'd14, 5'd0,  21'h18C200, 1'b0, 5'd14},
        '{6'h0D, 6'h00, 5'd2,  5'd15, 5'd0,  21'h18A100, 1'b0, 5'd15},
        '{6'h3F, 6'h00, 5'd1,  5'd2,  5'd3,  21'h000000, 1'b1, 5'd2},
        '{6'h00, 6'h05, 5'd1,  5'd2,  5'd3,  21'h000000, 1'b1, 5'd2}
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [20:0] c, input logic [4:0] d, input logic i, input logic [4:0] s);
        exp_t e;
        e.ctrl = c;
        e.dest = d;
        e.ill  = i;
        e.rs   = s;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        bus.op       = op;
        bus.fn       = fn;
        bus.rs       = rs;
        bus.rt       = rt;
        bus.rd       = rd;
        bus.in_valid = 1'b1;
    endtask

    task automatic expect_cycle(input string tag, input logic ir, input logic ov);
        @(negedge clk);
        check({tag, "_in_ready"}, bus.in_ready, ir);
        check({tag, "_out_valid"}, bus.out_valid, ov);
    endtask

    task automatic send(input vec_t v);
        bit done = 1'b0;
        drive(v.op, v.fn, v.rs, v.rt, v.rd);
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                push(v.ctrl, v.dest, v.ill, v.rs);
                done = 1'b1;
            end
            cyc();
        end
        bus.in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: every consume (out_valid & out_ready at the sampling edge) must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_ctrl", bus.ctrl, e.ctrl);
                    check("sb_dest", bus.out_dest, e.dest);
                    check("sb_illegal", bus.illegal, e.ill);
                    check("sb_out_rs", bus.out_rs, e.rs);
                    consumed++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c0;
        bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
        bus.op = '0; bus.fn = '0; bus.rs = '0; bus.rt = '0; bus.rd = '0;
        bus2.in_valid = 1'b0; bus2.flush = 1'b0; bus2.out_ready = 1'b1;
        bus2.op = '0; bus2.fn = '0; bus2.rs = '0; bus2.rt = '0; bus2.rd = '0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_ctrl", bus.ctrl, 21'h0);
        check("rst_illegal", bus.illegal, 1'b0);
        check("rst_dest", bus.out_dest, 5'd0);
        cyc();
        rst = 1'b0;

        // Single ADD, one-cycle latency
        drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3);
        expect_cycle("add", 1'b1, 1'b0);
        push(C_ADD, 5'd3, 1'b0, 5'd1);
        cyc();
        bus.in_valid = 1'b0;
        expect_cycle("add_out", 1'b1, 1'b1);
        check("add_ctrl", bus.ctrl, C_ADD);
        check("add_dest", bus.out_dest, 5'd3);
        cyc();
        expect_cycle("add_idle", 1'b1, 1'b0);
        cyc();

        // Ten back-to-back ADDs with consume+accept every cycle
        c0 = consumed;
        for (int i = 0; i < 10; i++) begin
            drive(6'h00, 6'h20, 5'(i + 1), 5'(i + 2), 5'(i + 10));
            @(negedge clk);
            check("b2b_in_ready", bus.in_ready, 1'b1);
            push(C_ADD, 5'(i + 10), 1'b0, 5'(i + 1));
            cyc();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("b2b_count", consumed - c0, 10);
        cyc();
        expect_cycle("b2b_drained", 1'b1, 1'b0);
        cyc();

        // Load-use hazard on rs: one bubble between LW and ADD
        drive(6'h23, 6'h00, 5'd1, 5'd5, 5'd0);
        expect_cycle("lu_lw", 1'b1, 1'b0);
        push(C_LW, 5'd5, 1'b0, 5'd1);
        cyc();
        drive(6'h00, 6'h20, 5'd5, 5'd2, 5'd6);
        expect_cycle("lu_stall", 1'b0, 1'b1);
        cyc();
        expect_cycle("lu_bubble", 1'b1, 1'b0);
        push(C_ADD, 5'd6, 1'b0, 5'd5);
        cyc();
        bus.in_valid = 1'b0;
        expect_cycle("lu_add", 1'b1, 1'b1);
        cyc();

        // Load-use on rt (BEQ stalls); ADDI that only writes rt, and LW to r0, must not stall
        drive(6'h23, 6'h00, 5'd1, 5'd7, 5'd0);
        expect_cycle("lu_rt_lw", 1'b1, 1'b0);
        push(C_LW, 5'd7, 1'b0, 5'd1);
        cyc();
        drive(6'h04, 6'h00, 5'd1, 5'd7, 5'd0);
        expect_cycle("lu_rt_stall", 1'b0, 1'b1);
        cyc();
        send('{6'h04, 6'h00, 5'd1, 5'd7, 5'd0, 21'h000004, 1'b0, 5'd7});
        send('{6'h23, 6'h00, 5'd1, 5'd5, 5'd0, C_LW, 1'b0, 5'd5});
        drive(6'h08, 6'h00, 5'd1, 5'd5, 5'd0);
        expect_cycle("nohaz_rt_writer", 1'b1, 1'b1);
        push(21'h18C200, 5'd5, 1'b0, 5'd1);
        cyc();
        send('{6'h23, 6'h00, 5'd1, 5'd0, 5'd0, C_LW, 1'b0, 5'd0});
        drive(6'h00, 6'h20, 5'd0, 5'd0, 5'd9);
        expect_cycle("nohaz_r0", 1'b1, 1'b1);
        push(C_ADD, 5'd9, 1'b0, 5'd0);
        cyc();
        bus.in_valid = 1'b0;
        repeat (2) cyc();

        // MUL with MUL_CYCLES=3, ADD waiting behind it
        drive(6'h00, 6'h28, 5'd7, 5'd8, 5'd9);
        expect_cycle("mul_c0", 1'b1, 1'b0);
        push(C_MUL, 5'd9, 1'b0, 5'd7);
        cyc();
        drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3);
        expect_cycle("mul_c1", 1'b0, 1'b0);
        cyc();
        expect_cycle("mul_c2", 1'b0, 1'b0);
        cyc();
        expect_cycle("mul_c3", 1'b0, 1'b1);
        cyc();
        expect_cycle("mul_c4", 1'b1, 1'b0);
        push(C_ADD, 5'd3, 1'b0, 5'd1);
        cyc();
        bus.in_valid = 1'b0;
        expect_cycle("mul_c5", 1'b1, 1'b1);
        cyc();

        // Flush while MUL busy with a pending instruction
        drive(6'h00, 6'h28, 5'd7, 5'd8, 5'd9);
        expect_cycle("fl_mul", 1'b1, 1'b0);
        cyc();
        drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3);
        bus.flush = 1'b1;
        expect_cycle("fl_assert", 1'b0, 1'b0);
        cyc();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        expect_cycle("fl_after", 1'b1, 1'b0);
        cyc();
        expect_cycle("fl_no_late1", 1'b1, 1'b0);
        cyc();
        expect_cycle("fl_no_late2", 1'b1, 1'b0);
        cyc();

        // Decode table, including illegal encodings
        foreach (vecs[i]) send(vecs[i]);
        repeat (2) cyc();

        // MUL on an instance without MUL support is illegal; ADD still decodes there
        bus2.op = 6'h00; bus2.fn = 6'h28; bus2.rs = 5'd7; bus2.rt = 5'd8; bus2.rd = 5'd9;
        bus2.in_valid = 1'b1;
        @(negedge clk);
        check("nomul_in_ready", bus2.in_ready, 1'b1);
        cyc();
        bus2.fn = 6'h20;
        @(negedge clk);
        check("nomul_out_valid", bus2.out_valid, 1'b1);
        check("nomul_illegal", bus2.illegal, 1'b1);
        check("nomul_ctrl", bus2.ctrl, 21'h0);
        cyc();
        bus2.in_valid = 1'b0;
        @(negedge clk);
        check("nomul_add_illegal", bus2.illegal, 1'b0);
        check("nomul_add_ctrl", bus2.ctrl, C_ADD);
        cyc();

        // Asynchronous reset while an ADD is held with out_ready low
        bus.out_ready = 1'b0;
        drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3);
        expect_cycle("ar_accept", 1'b1, 1'b0);
        push(C_ADD, 5'd3, 1'b0, 5'd1);
        cyc();
        bus.in_valid = 1'b0;
        expect_cycle("ar_hold", 1'b0, 1'b1);
        cyc();
        #2;
        rst = 1'b1;
        #1;
        check("ar_out_valid", bus.out_valid, 1'b0);
        check("ar_ctrl", bus.ctrl, 21'h0);
        check("ar_dest", bus.out_dest, 5'd0);
        check("ar_in_ready", bus.in_ready, 1'b0);
        exp_q.delete();
        cyc();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        expect_cycle("ar_release", 1'b1, 1'b0);
        cyc();

        check("sb_drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
